// File: rtl/win_pkg.sv
// Shared window-path definitions: state codes and travel directions.
// Reused by window_actuator and by the command FSM bench.
package win_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_OPENING  = 3'd1;
   localparam logic [2:0] ST_CLOSING  = 3'd2;
   localparam logic [2:0] ST_DEADTIME = 3'd3;
   localparam logic [2:0] ST_FAULT    = 3'd4;

   localparam logic DIR_OPEN  = 1'b0;
   localparam logic DIR_CLOSE = 1'b1;

   // Counter width able to hold the larger of the two terminal counts.
   function automatic int timer_w(input int t, input int d);
      int m;
      m = (t > d) ? t : d;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/window_actuator_if.sv
// Command, sensor and motor-pin bundle between the window FSM and actuator.
// master: command/sensor side; slave: the actuator.
interface window_actuator_if;

   logic OPEN_CW;
   logic CLOSE_CW;
   logic LIMIT_OPEN;
   logic LIMIT_CLOSED;
   logic OBSTACLE;
   logic CLR_FAULT;
   logic MOTOR_OPEN;
   logic MOTOR_CLOSE;
   logic BUSY;
   logic FAULT;

   modport master (
      output OPEN_CW,
      output CLOSE_CW,
      output LIMIT_OPEN,
      output LIMIT_CLOSED,
      output OBSTACLE,
      output CLR_FAULT,
      input  MOTOR_OPEN,
      input  MOTOR_CLOSE,
      input  BUSY,
      input  FAULT
   );

   modport slave (
      input  OPEN_CW,
      input  CLOSE_CW,
      input  LIMIT_OPEN,
      input  LIMIT_CLOSED,
      input  OBSTACLE,
      input  CLR_FAULT,
      output MOTOR_OPEN,
      output MOTOR_CLOSE,
      output BUSY,
      output FAULT
   );

endinterface

// File: rtl/win_timer.sv
// Clearable saturating up-counter shared by travel timeout and dead time.
// Flags fire on the last cycle of each interval so the FSM leaves on time.
module win_timer #(
   parameter int W            = 10,
   parameter int TIMEOUT_CYC  = 1000,
   parameter int DEADTIME_CYC = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic tc_timeout,
   output logic tc_dead
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         sat;

   assign sat = &cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !sat) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_timeout = (cnt_q == W'(TIMEOUT_CYC - 1));
   assign tc_dead    = (cnt_q == W'(DEADTIME_CYC - 1));

endmodule

// File: rtl/window_actuator.sv
// Window motor executor: travel to limit, reversal dead time, fault supervision.
// Optional pinch auto-reverse is built only when WIN_OBSTACLE_EN is defined.
module window_actuator
   import win_pkg::*;
#(
   parameter int TIMEOUT_CYC  = 1000,
   parameter int DEADTIME_CYC = 4
) (
   input logic               CLK,
   input logic               RST,
   window_actuator_if.slave  bus
);

   localparam int TW = timer_w(TIMEOUT_CYC, DEADTIME_CYC);

   logic [2:0] state_q;
   logic [2:0] state_d;
   logic       pend_q;
   logic       pend_d;
   logic       motor_open_q;
   logic       motor_open_d;
   logic       motor_close_q;
   logic       motor_close_d;
   logic       busy_q;
   logic       busy_d;
   logic       fault_q;
   logic       fault_d;
   logic       tc_timeout;
   logic       tc_dead;
   logic       tmr_clr;
   logic       tmr_en;
   logic       obs_hit;
   logic       lim_conflict;

`ifdef WIN_OBSTACLE_EN
   assign obs_hit = bus.OBSTACLE;
`else
   assign obs_hit = 1'b0;
`endif

   assign lim_conflict = bus.LIMIT_OPEN & bus.LIMIT_CLOSED;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.OPEN_CW && bus.CLOSE_CW) begin
               state_d = ST_IDLE;
            end else if (bus.OPEN_CW && !bus.LIMIT_OPEN) begin
               state_d = ST_OPENING;
            end else if (bus.CLOSE_CW && !bus.LIMIT_CLOSED && !obs_hit) begin
               state_d = ST_CLOSING;
            end
         end
         ST_OPENING: begin
            if (bus.LIMIT_OPEN) begin
               state_d = ST_IDLE;
            end else if (tc_timeout) begin
               state_d = ST_FAULT;
            end else if (bus.CLOSE_CW) begin
               state_d = ST_DEADTIME;
               pend_d  = DIR_CLOSE;
            end
         end
         ST_CLOSING: begin
            // Pinch detection reverses the same way a manual open does.
            if (bus.LIMIT_CLOSED) begin
               state_d = ST_IDLE;
            end else if (tc_timeout) begin
               state_d = ST_FAULT;
            end else if (bus.OPEN_CW || obs_hit) begin
               state_d = ST_DEADTIME;
               pend_d  = DIR_OPEN;
            end
         end
         ST_DEADTIME: begin
            if (tc_dead) begin
               if (pend_q == DIR_OPEN) begin
                  state_d = bus.LIMIT_OPEN ? ST_IDLE : ST_OPENING;
               end else begin
                  state_d = bus.LIMIT_CLOSED ? ST_IDLE : ST_CLOSING;
               end
            end
         end
         ST_FAULT: begin
            if (bus.CLR_FAULT) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
      // Both limits at once means a broken sensor; overrides everything.
      if (state_q != ST_FAULT && lim_conflict) begin
         state_d = ST_FAULT;
      end
   end

   assign tmr_clr = (state_d != state_q);
   assign tmr_en  = (state_q == ST_OPENING) ||
                    (state_q == ST_CLOSING) ||
                    (state_q == ST_DEADTIME);

   win_timer #(
      .W            (TW),
      .TIMEOUT_CYC  (TIMEOUT_CYC),
      .DEADTIME_CYC (DEADTIME_CYC)
   ) u_timer (
      .CLK        (CLK),
      .RST        (RST),
      .clr        (tmr_clr),
      .en         (tmr_en),
      .tc_timeout (tc_timeout),
      .tc_dead    (tc_dead)
   );

   always_comb begin
      motor_open_d  = (state_d == ST_OPENING);
      motor_close_d = (state_d == ST_CLOSING);
      busy_d        = (state_d == ST_OPENING) ||
                      (state_d == ST_CLOSING) ||
                      (state_d == ST_DEADTIME);
      fault_d       = (state_d == ST_FAULT);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= ST_IDLE;
         pend_q        <= DIR_OPEN;
         motor_open_q  <= 1'b0;
         motor_close_q <= 1'b0;
         busy_q        <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         motor_open_q  <= motor_open_d;
         motor_close_q <= motor_close_d;
         busy_q        <= busy_d;
         fault_q       <= fault_d;
      end
   end

   assign bus.MOTOR_OPEN  = motor_open_q;
   assign bus.MOTOR_CLOSE = motor_close_q;
   assign bus.BUSY        = busy_q;
   assign bus.FAULT       = fault_q;

endmodule

// File: tb/tb_window_actuator.sv
// Directed bench for window_actuator with TIMEOUT_CYC=20, DEADTIME_CYC=4.
// Observed vector is {MOTOR_OPEN, MOTOR_CLOSE, BUSY, FAULT}.
module tb_window_actuator;

   localparam int TO = 20;
   localparam int DT = 4;

   localparam logic [3:0] V_IDLE  = 4'b0000;
   localparam logic [3:0] V_OPEN  = 4'b1010;
   localparam logic [3:0] V_CLOSE = 4'b0110;
   localparam logic [3:0] V_DEAD  = 4'b0010;
   localparam logic [3:0] V_FLT   = 4'b0001;

   logic CLK;
   logic RST;
   int   checks;
   int   errors;
   logic [3:0] obs;

   window_actuator_if bus ();

   window_actuator #(
      .TIMEOUT_CYC  (TO),
      .DEADTIME_CYC (DT)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   assign obs = {bus.MOTOR_OPEN, bus.MOTOR_CLOSE, bus.BUSY, bus.FAULT};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      bus.OPEN_CW = 1'b0;
      bus.CLOSE_CW = 1'b0;
      bus.LIMIT_OPEN = 1'b0;
      bus.LIMIT_CLOSED = 1'b0;
      bus.OBSTACLE = 1'b0;
      bus.CLR_FAULT = 1'b0;
      tick();
      tick();
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL reset got %b want %b", obs, V_IDLE);
      end
      RST = 1'b1;
      tick();
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL reset_release got %b want %b", obs, V_IDLE);
      end
   endtask

   task automatic test_normal_open();
      bus.OPEN_CW = 1'b1;
      tick();
      bus.OPEN_CW = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         checks++;
         if (obs !== V_OPEN) begin
            errors++;
            $display("FAIL open cyc %0d got %b want %b", c, obs, V_OPEN);
         end
         if (c == 10) bus.LIMIT_OPEN = 1'b1;
         tick();
      end
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL open_stop got %b want %b", obs, V_IDLE);
      end
      bus.OPEN_CW = 1'b1;
      tick();
      bus.OPEN_CW = 1'b0;
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL open_at_limit got %b want %b", obs, V_IDLE);
      end
      bus.LIMIT_OPEN = 1'b0;
      tick();
   endtask

   task automatic test_reversal();
      logic [3:0] exp;
      bus.OPEN_CW = 1'b1;
      tick();
      bus.OPEN_CW = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         if (c <= 5) exp = V_OPEN;
         else if (c <= 9) exp = V_DEAD;
         else exp = V_CLOSE;
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reverse cyc %0d got %b want %b", c, obs, exp);
         end
         bus.CLOSE_CW = (c == 5);
         bus.OPEN_CW = (c == 7);
         if (c == 11) bus.LIMIT_CLOSED = 1'b1;
         tick();
      end
      bus.CLOSE_CW = 1'b0;
      bus.OPEN_CW = 1'b0;
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL reverse_stop got %b want %b", obs, V_IDLE);
      end
      bus.LIMIT_CLOSED = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      bus.OPEN_CW = 1'b1;
      tick();
      bus.OPEN_CW = 1'b0;
      for (int c = 1; c <= TO; c++) begin
         checks++;
         if (obs !== V_OPEN) begin
            errors++;
            $display("FAIL timeout_run cyc %0d got %b want %b", c, obs, V_OPEN);
         end
         tick();
      end
      checks++;
      if (obs !== V_FLT) begin
         errors++;
         $display("FAIL timeout_fault got %b want %b", obs, V_FLT);
      end
      bus.OPEN_CW = 1'b1;
      tick();
      bus.OPEN_CW = 1'b0;
      tick();
      checks++;
      if (obs !== V_FLT) begin
         errors++;
         $display("FAIL fault_holds got %b want %b", obs, V_FLT);
      end
      bus.CLR_FAULT = 1'b1;
      tick();
      bus.CLR_FAULT = 1'b0;
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL clr_fault got %b want %b", obs, V_IDLE);
      end
   endtask

   task automatic test_conflict();
      bus.CLOSE_CW = 1'b1;
      tick();
      bus.CLOSE_CW = 1'b0;
      checks++;
      if (obs !== V_CLOSE) begin
         errors++;
         $display("FAIL conflict_close got %b want %b", obs, V_CLOSE);
      end
      tick();
      bus.LIMIT_OPEN = 1'b1;
      bus.LIMIT_CLOSED = 1'b1;
      tick();
      bus.LIMIT_OPEN = 1'b0;
      bus.LIMIT_CLOSED = 1'b0;
      checks++;
      if (obs !== V_FLT) begin
         errors++;
         $display("FAIL conflict_fault got %b want %b", obs, V_FLT);
      end
      bus.CLR_FAULT = 1'b1;
      tick();
      bus.CLR_FAULT = 1'b0;
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL conflict_clr got %b want %b", obs, V_IDLE);
      end
   endtask

   task automatic test_redundant();
      bus.LIMIT_CLOSED = 1'b1;
      bus.CLOSE_CW = 1'b1;
      tick();
      bus.CLOSE_CW = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL redundant cyc %0d got %b want %b", c, obs, V_IDLE);
         end
         tick();
      end
      bus.LIMIT_CLOSED = 1'b0;
   endtask

   task automatic test_simultaneous();
      bus.OPEN_CW = 1'b1;
      bus.CLOSE_CW = 1'b1;
      tick();
      bus.OPEN_CW = 1'b0;
      bus.CLOSE_CW = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         checks++;
         if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL simultaneous cyc %0d got %b want %b", c, obs, V_IDLE);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      bus.CLOSE_CW = 1'b1;
      tick();
      bus.CLOSE_CW = 1'b0;
      tick();
      tick();
      checks++;
      if (obs !== V_CLOSE) begin
         errors++;
         $display("FAIL rst_mid_pre got %b want %b", obs, V_CLOSE);
      end
      #2;
      RST = 1'b0;
      #1;
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL rst_mid_async got %b want %b", obs, V_IDLE);
      end
      tick();
      RST = 1'b1;
      tick();
      tick();
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL rst_mid_after got %b want %b", obs, V_IDLE);
      end
   endtask

   task automatic test_obstacle();
      logic [3:0] exp;
      bus.CLOSE_CW = 1'b1;
      tick();
      bus.CLOSE_CW = 1'b0;
      for (int c = 1; c <= 10; c++) begin
`ifdef WIN_OBSTACLE_EN
         if (c <= 3) exp = V_CLOSE;
         else if (c <= 7) exp = V_DEAD;
         else exp = V_OPEN;
`else
         exp = V_CLOSE;
`endif
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL obstacle cyc %0d got %b want %b", c, obs, exp);
         end
         bus.OBSTACLE = (c == 3);
`ifdef WIN_OBSTACLE_EN
         bus.LIMIT_OPEN = (c == 10);
`else
         bus.LIMIT_CLOSED = (c == 10);
`endif
         tick();
      end
      bus.OBSTACLE = 1'b0;
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL obstacle_stop got %b want %b", obs, V_IDLE);
      end
      bus.LIMIT_OPEN = 1'b0;
      bus.LIMIT_CLOSED = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_normal_open();
      test_reversal();
      test_timeout();
      test_conflict();
      test_redundant();
      test_simultaneous();
      test_reset_mid();
      test_obstacle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
